// File: rtl/coin_pkg.sv
// Shared coin codes (common with the vending FSM) and the acceptor's state encoding.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    // Edges after reset before the synchroniser outputs reflect real sensor samples.
    localparam int unsigned SYNC_FILL = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUAL,
        ST_EMIT,
        ST_RELEASE,
        ST_REJECT,
        ST_JAM
    } coin_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for one asynchronous sensor line.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin-slot front end: synchronise, debounce and qualify sensor pulses into one-cycle
// coin codes, with reject on both-sensor insertions and jam detection on stuck sensors.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 64,
    parameter int unsigned CNT_W           = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_5,
    input  logic       sens_10,
    output logic [1:0] coin_out,
    output logic       coin_reject,
    output logic       jam,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] JAM_MAX = CNT_W'(JAM_CYCLES);
    localparam logic [1:0]       FILL    = 2'(SYNC_FILL);

    coin_state_t      state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic [1:0]       coin_q, coin_next;
    logic [1:0]       fill;
    logic             armed;
    logic             s5, s10;
    logic             lat_hi, oth_hi;
    logic [1:0]       coin_d;
    logic             reject_d, jam_d, busy_d;

    sync2 u_sync_5  (.clk(clk), .reset(reset), .d(sens_5),  .q(s5));
    sync2 u_sync_10 (.clk(clk), .reset(reset), .d(sens_10), .q(s10));

    // A coin already present at reset is not accepted until both sensors have been seen low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill  <= 2'd0;
            armed <= 1'b0;
        end else begin
            fill  <= (fill == FILL) ? fill : fill + 2'd1;
            armed <= armed | ((fill == FILL) && !s5 && !s10);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            coin_q <= COIN_NONE;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            coin_q <= coin_next;
        end
    end

    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign lat_hi  = (coin_q == COIN_5) ? s5  : s10;
    assign oth_hi  = (coin_q == COIN_5) ? s10 : s5;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        coin_next  = coin_q;
        unique case (state)
            ST_IDLE: begin
                if (armed) begin
                    if (s5 && s10) begin
                        state_next = ST_REJECT;
                    end else if (s5 || s10) begin
                        state_next = ST_QUAL;
                        cnt_next   = CNT_W'(1);
                        coin_next  = s5 ? COIN_5 : COIN_10;
                    end
                end
            end
            ST_QUAL: begin
                if (oth_hi) begin
                    state_next = ST_REJECT;
                end else if (!lat_hi) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt >= DEB_MAX) begin
                    state_next = ST_EMIT;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_EMIT, ST_REJECT: begin
                state_next = ST_RELEASE;
                cnt_next   = '0;
            end
            ST_RELEASE: begin
                if (!s5 && !s10) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= JAM_MAX) begin
                        state_next = ST_JAM;
                    end
                end
            end
            ST_JAM: begin
                if (!s5 && !s10) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Pulses register the current state (one cycle behind); levels track the next state.
    always_comb begin
        coin_d   = COIN_NONE;
        reject_d = 1'b0;
        jam_d    = 1'b0;
        busy_d   = 1'b0;
        if (state == ST_EMIT) begin
            coin_d = coin_q;
        end
        if (state == ST_REJECT) begin
            reject_d = 1'b1;
        end
        if (state_next == ST_JAM) begin
            jam_d = 1'b1;
        end
        if (state_next != ST_IDLE) begin
            busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coin_out    <= COIN_NONE;
            coin_reject <= 1'b0;
            jam         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            coin_out    <= coin_d;
            coin_reject <= reject_d;
            jam         <= jam_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus random insertions,
// every cycle compared against a behavioural model of the acceptor.
module tb_coin_acceptor;

    localparam int D = 4;
    localparam int J = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sens_5 = 1'b0;
    logic       sens_10 = 1'b0;
    logic [1:0] coin_out;
    logic       coin_reject, jam, busy;

    int n_tests = 0;
    int n_fail  = 0;

    coin_acceptor dut (
        .clk(clk), .reset(reset), .sens_5(sens_5), .sens_10(sens_10),
        .coin_out(coin_out), .coin_reject(coin_reject), .jam(jam), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: sensor delay line, then "qualifying for n cycles", "holding until both low
    // (with stuck-high age)", and pending emit/reject pulses.
    typedef struct packed {
        logic [1:0] p1, p2;
        logic [1:0] fill;
        logic       armed;
        int         qual;
        logic [1:0] qcoin;
        logic       emit_now, rej_now, hold;
        int         stuck;
        logic [1:0] coin;
        logic       rej, jm, bsy;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_step(mstate_t c, logic r5, logic r10);
        mstate_t n;
        logic [1:0] s;
        logic lat, oth;
        n = c;
        s = c.p2;
        n.p1 = {r10, r5};
        n.p2 = c.p1;
        n.fill  = (c.fill == 2'd2) ? 2'd2 : c.fill + 2'd1;
        n.armed = c.armed | (c.fill == 2'd2 && s == 2'b00);
        n.coin  = c.emit_now ? c.qcoin : 2'b00;
        n.rej   = c.rej_now;
        n.emit_now = 1'b0;
        n.rej_now  = 1'b0;
        if (c.emit_now || c.rej_now) begin
            n.hold = 1'b1;
            n.stuck = 0;
        end else if (c.hold) begin
            if (s == 2'b00) begin
                n.hold = 1'b0;
                n.stuck = 0;
            end else begin
                n.stuck = (c.stuck >= 127) ? 127 : c.stuck + 1;
            end
        end else if (c.qual > 0) begin
            lat = (c.qcoin == 2'b01) ? s[0] : s[1];
            oth = (c.qcoin == 2'b01) ? s[1] : s[0];
            if (oth) begin
                n.rej_now = 1'b1;
                n.qual = 0;
            end else if (!lat) begin
                n.qual = 0;
            end else if (c.qual >= D) begin
                n.emit_now = 1'b1;
                n.qual = 0;
            end else begin
                n.qual = c.qual + 1;
            end
        end else if (c.armed) begin
            if (s == 2'b11) begin
                n.rej_now = 1'b1;
            end else if (s != 2'b00) begin
                n.qual = 1;
                n.qcoin = s[0] ? 2'b01 : 2'b10;
            end
        end
        n.jm  = n.hold && (n.stuck >= J);
        n.bsy = (n.qual > 0) || n.emit_now || n.rej_now || n.hold;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else        m <= model_step(m, sens_5, sens_10);
    end

    logic [4:0] obs, exp_o;
    assign obs   = {coin_out, coin_reject, jam, busy};
    assign exp_o = {m.coin, m.rej, m.jm, m.bsy};

    task automatic tick(input logic a, input logic b);
        sens_5  = a;
        sens_10 = b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000", obs);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 1'b0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got %b want %b", i, obs, exp_o);
            end
        end
    endtask

    task automatic test_clean_5();
        int codes = 0, idx = -1;
        for (int i = 0; i < 30; i++) begin
            tick(i < 20, 1'b0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL clean_5 cyc%0d: got %b want %b", i, obs, exp_o);
            end
            if (coin_out != 2'b00) begin
                codes++;
                if (idx < 0) idx = i;
            end
        end
        n_tests++;
        if (codes !== 1 || idx !== D + 3) begin
            n_fail++;
            $display("FAIL clean_5_latency: codes %0d at %0d want 1 at %0d", codes, idx, D + 3);
        end
    endtask

    task automatic test_glitch_10();
        int codes = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1'b0, i < 2);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL glitch_10 cyc%0d: got %b want %b", i, obs, exp_o);
            end
            if (coin_out != 2'b00) codes++;
        end
        n_tests++;
        if (codes !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_10_idle: codes %0d busy %b want 0 0", codes, busy);
        end
    endtask

    task automatic test_reject();
        int codes = 0, rejs = 0;
        for (int i = 0; i < 20; i++) begin
            tick(i >= 2 && i < 10, i < 10);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reject cyc%0d: got %b want %b", i, obs, exp_o);
            end
            if (coin_out != 2'b00) codes++;
            if (coin_reject) rejs++;
        end
        n_tests++;
        if (codes !== 0 || rejs !== 1) begin
            n_fail++;
            $display("FAIL reject_count: codes %0d rejects %0d want 0 1", codes, rejs);
        end
    endtask

    task automatic test_jam();
        int code_idx = -1, jam_idx = -1, codes = 0;
        for (int i = 0; i < 110; i++) begin
            tick(i < 100, 1'b0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL jam cyc%0d: got %b want %b", i, obs, exp_o);
            end
            if (coin_out != 2'b00) begin
                codes++;
                code_idx = i;
            end
            if (jam && jam_idx < 0) jam_idx = i;
        end
        n_tests++;
        if (codes !== 1 || jam_idx !== code_idx + J) begin
            n_fail++;
            $display("FAIL jam_timing: codes %0d jam at %0d want 1 at %0d", codes, jam_idx, code_idx + J);
        end
        n_tests++;
        if (jam !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL jam_release: jam %b busy %b want 0 0", jam, busy);
        end
    endtask

    task automatic test_reset_mid_qual();
        int codes = 0;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1);
        reset = 1'b0;
        #1;
        n_tests++;
        if (obs !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid_qual: got %b want 00000", obs);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0, (i < 20) || (i >= 24 && i < 34));
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL reset_mid_qual cyc%0d: got %b want %b", i, obs, exp_o);
            end
            if (coin_out != 2'b00) begin
                codes++;
                n_tests++;
                if (i < 24 || coin_out !== 2'b10) begin
                    n_fail++;
                    $display("FAIL reset_mid_qual_code: got %b at %0d want 10 after 24", coin_out, i);
                end
            end
        end
        n_tests++;
        if (codes !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_qual_count: codes %0d want 1", codes);
        end
    endtask

    task automatic test_back_to_back();
        int codes = 0, rejs = 0;
        for (int i = 0; i < 40; i++) begin
            tick((i < 10) || (i >= 13 && i < 23), 1'b0);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs, exp_o);
            end
            if (coin_out == 2'b01) codes++;
            if (coin_reject) rejs++;
        end
        n_tests++;
        if (codes !== 2 || rejs !== 0) begin
            n_fail++;
            $display("FAIL back_to_back_count: codes %0d rejects %0d want 2 0", codes, rejs);
        end
    endtask

    task automatic test_random();
        int kind, len, lag, gap;
        logic a, b;
        for (int seg = 0; seg < 60; seg++) begin
            kind = $urandom_range(0, 5);
            len  = (kind == 5) ? $urandom_range(66, 90) : $urandom_range(1, 12);
            lag  = $urandom_range(1, 6);
            gap  = $urandom_range(1, 6);
            for (int i = 0; i < len + gap; i++) begin
                a = 1'b0;
                b = 1'b0;
                if (i < len) begin
                    case (kind)
                        0:       a = 1'b1;
                        1:       b = 1'b1;
                        2:       begin a = 1'b1; b = 1'b1; end
                        3:       begin a = 1'b1; b = (i >= lag); end
                        4:       begin b = 1'b1; a = (i >= lag); end
                        default: a = $urandom_range(0, 1) == 1;
                    endcase
                    if (kind == 5) b = 1'b0;
                end
                tick(a, b);
                n_tests++;
                if (obs !== exp_o) begin
                    n_fail++;
                    $display("FAIL random seg%0d cyc%0d: got %b want %b", seg, i, obs, exp_o);
                end
                n_tests++;
                if (coin_out === 2'b11) begin
                    n_fail++;
                    $display("FAIL random_code11 seg%0d: got 11 want not 11", seg);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_5();
        test_glitch_10();
        test_reject();
        test_jam();
        test_reset_mid_qual();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
